// File: rtl/switch_debounce.sv
// Per-channel switch debouncer: 2-flop synchronizer plus a STABLE/COUNTING FSM per bit.
// Optional edge pulses (rise_pulse/fall_pulse) enabled by SWITCH_DEBOUNCE_EDGE_PULSE_EN.
module switch_debounce #(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] out_port,
  output logic             change
`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
  ,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] toggle_c;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             change_q;
  logic             change_d;

  // Synchronizer for the asynchronous board levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
    end
  end

  // Per-channel state and counter registers.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (reset) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic; toggle_c flags channels whose stable period completes this cycle.
  always_comb begin
    toggle_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (s2_q[i] != out_q[i]) begin
            state_d[i] = ST_COUNTING;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        ST_COUNTING: begin
          if (s2_q[i] == out_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            toggle_c[i] = 1'b1;
            state_d[i]  = ST_STABLE;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign out_d    = out_q ^ toggle_c;
  assign change_d = |toggle_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= RESET_VAL;
      change_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      change_q <= change_d;
    end
  end

  assign out_port = out_q;
  assign change   = change_q;

`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Edge direction comes from the pre-toggle level of each channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= toggle_c & ~out_q;
      fall_q <= toggle_c & out_q;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: per-edge "D consecutive differing samples" model plus directed literals.
module tb_switch_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] raw_in;
  logic [7:0] out_port;
  logic       change;
`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
  logic [7:0] rise_pulse;
  logic [7:0] fall_pulse;
`endif

  int vectors     = 0;
  int miscompares = 0;

  switch_debounce #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(D),
    .RESET_VAL      (8'h00)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .raw_in  (raw_in),
    .out_port(out_port),
    .change  (change)
`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
    ,
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`endif
  );

  always #5 clk = ~clk;

  // Model: a bit flips at edge n when the raw samples of edges n-D-1..n-2 all differ
  // from its current level and no reset occurred in edges n-D-1..n.
  logic [7:0] raw_h [0:4095];
  bit         rst_h [0:4095];
  int         edge_n  = 0;
  bit         m_valid = 0;
  logic [7:0] m_out, m_rise, m_fall, tog;
  logic       m_chg;
  bit         ok;

  always @(posedge clk) begin
    raw_h[edge_n] = raw_in;
    rst_h[edge_n] = reset;
    if (reset) begin
      m_valid = 1;
      m_out   = 8'h00;
      m_chg   = 1'b0;
      m_rise  = 8'h00;
      m_fall  = 8'h00;
    end else begin
      tog = 8'h00;
      for (int b = 0; b < 8; b++) begin
        ok = 1;
        for (int k = edge_n - D - 1; k <= edge_n; k++)
          if (k < 0 || rst_h[k]) ok = 0;
        for (int k = edge_n - D - 1; k <= edge_n - 2; k++)
          if (k >= 0 && raw_h[k][b] == m_out[b]) ok = 0;
        tog[b] = ok;
      end
      m_rise = tog & ~m_out;
      m_fall = tog & m_out;
      m_out  = m_out ^ tog;
      m_chg  = |tog;
    end
    edge_n++;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model out_port", out_port, m_out);
      chk("model change", 8'(change), 8'(m_chg));
`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
      chk("model rise_pulse", rise_pulse, m_rise);
      chk("model fall_pulse", fall_pulse, m_fall);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] raw, input int cycles);
    raw_in = raw;
    reset  = 1'b1;
    step(cycles);
    reset  = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 8'hFF;
    // Reset with all switches pressed: no update until the full debounce path.
    step(2);
    chk("rst out", out_port, 8'h00);
    chk("rst change", 8'(change), 8'h00);
    reset = 1'b0;
    step(5);
    chk("rel e4 out", out_port, 8'h00);
    step(1);
    chk("rel e5 out", out_port, 8'hFF);
    chk("rel e5 change", 8'(change), 8'h01);
    step(1);
    chk("rel e6 change", 8'(change), 8'h00);

    // Single rising channel.
    do_reset(8'h00, 2);
    step(8);
    chk("idle out", out_port, 8'h00);
    raw_in = 8'h01;
    step(5);
    chk("b0 e4 out", out_port, 8'h00);
    step(1);
    chk("b0 e5 out", out_port, 8'h01);
    chk("b0 e5 change", 8'(change), 8'h01);
`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
    chk("b0 e5 rise", rise_pulse, 8'h01);
`endif
    step(1);
    chk("b0 e6 change", 8'(change), 8'h00);
`ifdef SWITCH_DEBOUNCE_EDGE_PULSE_EN
    chk("b0 e6 rise", rise_pulse, 8'h00);
`endif

    // Three-cycle glitch on bit 3 is rejected.
    raw_in = 8'h09;
    step(3);
    raw_in = 8'h01;
    step(10);
    chk("glitch out", out_port, 8'h01);

    // Bouncing bit 5 restarts the period from the last transition.
    raw_in = 8'h21; step(1);
    raw_in = 8'h01; step(1);
    raw_in = 8'h21; step(1);
    raw_in = 8'h01; step(1);
    raw_in = 8'h21;
    step(5);
    chk("bounce e4 out", out_port, 8'h01);
    step(1);
    chk("bounce e5 out", out_port, 8'h21);
    chk("bounce e5 change", 8'(change), 8'h01);

    // Simultaneous rise on bits 0 and 7: one pulse.
    raw_in = 8'h00;
    step(8);
    chk("clear out", out_port, 8'h00);
    raw_in = 8'h81;
    step(6);
    chk("simul out", out_port, 8'h81);
    chk("simul change", 8'(change), 8'h01);
    step(1);
    chk("simul after change", 8'(change), 8'h00);

    // Staggered by two cycles: two separate pulses.
    raw_in = 8'h00;
    step(8);
    raw_in = 8'h01;
    step(2);
    raw_in = 8'h81;
    step(4);
    chk("stag1 out", out_port, 8'h01);
    chk("stag1 change", 8'(change), 8'h01);
    step(1);
    chk("stag gap change", 8'(change), 8'h00);
    step(1);
    chk("stag2 out", out_port, 8'h81);
    chk("stag2 change", 8'(change), 8'h01);

    // Reset mid-count on bit 2 aborts and requires a full new period.
    raw_in = 8'h00;
    step(8);
    raw_in = 8'h04;
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("abort out", out_port, 8'h00);
    step(5);
    chk("abort e4 out", out_port, 8'h00);
    step(1);
    chk("abort e5 out", out_port, 8'h04);
    chk("abort e5 change", 8'(change), 8'h01);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
